dp_controller: RTL and testbench
================================

# dp_controller

Multi-cycle control unit that sits directly upstream of the ARM32 datapath. It accepts one 32-bit ARM data-processing instruction at a time and evaluates its condition field against the datapath status flags. It then sequences the datapath strobes through operand load, execute and write-back. All datapath select/address/immediate fields are decoded from a latched copy of the instruction.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is presented
- instr_ready  out  1  controller is idle and can accept (high in IDLE, including during reset)
- status_in  in  32  datapath status; N=[31], Z=[30], C=[29], V=[28]
- done  out  1  one-cycle pulse when the instruction retires, executed or skipped
- undef  out  1  one-cycle pulse, coincident with done, for unsupported opcode or cond=1111
- w_addr, A_addr, B_addr, shift_addr  out  4 each  register addresses
- wb_sel  out  1  tied 0 (write-back from C)
- w_en, en_A, en_B, en_C, en_status  out  1 each  datapath strobes
- shift_op  out  2  shift type
- shift_imme  out  32  zero-extended 5-bit shift amount
- sel_shift  out  1  0=immediate shift amount, 1=register shift amount
- sel_A  out  1  1 forces ALU A to zero
- sel_B  out  1  1 selects imme_data
- imme_data  out  32  rotated immediate
- ALU_op  out  3  ALU operation

## Operation
- Accept on instr_valid && instr_ready; instr is latched into ir. All decoded outputs derive from ir only and stay stable until IDLE.
- Fields: cond=ir[31:28], I=ir[25], opc=ir[24:21], S=ir[20], Rn→A_addr, Rd→w_addr, Rm=ir[3:0]→B_addr, shift_op=ir[6:5].
- I=1: sel_B=1; imme_data = {24'b0, ir[7:0]} rotated right by 2*ir[11:8].
- I=0: sel_B=0. If ir[4]=0: sel_shift=0, shift_imme=ir[11:7]. If ir[4]=1: sel_shift=1, shift_addr=ir[11:8].
- Opcodes and ALU_op: AND 0000→010; EOR 0001→100; SUB 0010→001; ADD 0100→000; ORR 1100→011; MOV 1101→000 with sel_A=1; CMP 1010→001 with no write-back and en_status forced on. Every other opcode is undefined.
- Conditions are the standard ARM codes 0000 EQ through 1110 AL, evaluated on status_in in DECODE. Code 1111 is undefined.
- FSM states:
  - IDLE: accept → DECODE.
  - DECODE: undefined opcode or cond 1111 → DONE with undef set; condition fails → DONE; otherwise → LOAD.
  - LOAD: en_A=en_B=1 → EXEC.
  - EXEC: en_C=1; en_status = S or CMP → WB.
  - WB: w_en=1 unless CMP → DONE.
  - DONE: done=1 → IDLE.
- Strobes are Moore outputs and are 0 in every state not listed above. A skipped or undefined instruction produces no en_A/en_B/en_C/en_status/w_en.

## Timing
- Reset (asynchronous, rst_n low): state=IDLE, ir=0, all strobes/done/undef=0, instr_ready=1. Reset mid-instruction aborts it; no further strobes follow.
- Executed instruction: accept edge, then DECODE, LOAD, EXEC, WB, DONE, each one cycle. done is high 5 cycles after the accept edge. Throughput is 1 instruction per 6 cycles.
- Skipped or undefined instruction: DECODE → DONE, so done is high 2 cycles after accept.
- instr and instr_valid are ignored outside IDLE. A new instruction may be accepted in the cycle immediately after DONE.
- status_in is sampled only in DECODE. A flag update by the previous instruction's EXEC is visible because at least 2 edges separate them.

## Structure
- Package arm_ctrl_pkg:
  - state enum (IDLE, DECODE, LOAD, EXEC, WB, DONE)
  - ALU_op localparams
  - opcode localparams
  - condition-code localparams
- One combinational sub-module, cond_check (cond[3:0], nzcv[3:0] → pass). It is unit-testable on its own.

## Test plan
- 0xE2821005 (ADD R1,R2,#5): A_addr=2, w_addr=1, sel_B=1, imme_data=5, ALU_op=000; strobes en_A/en_B, en_C, w_en on consecutive cycles; done at +5; en_status never high.
- 0xE0533104 (SUBS R3,R3,R4 LSL #2): B_addr=4, shift_op=00, sel_shift=0, shift_imme=2, ALU_op=001, en_status=1 in EXEC, w_addr=3.
- 0x03A004FF (MOVEQ R0,#0xFF000000):
  - With Z=1: imme_data=0xFF000000, sel_A=1, w_en in WB.
  - With Z=0: done at +2, no strobes.
- 0xE1510002 (CMP R1,R2): en_status=1 in EXEC; w_en stays 0 for the whole instruction.
- 0xE0610002 (RSB, unsupported): done and undef pulse together at +2; no strobes; instr_ready back to 1 the next cycle.
- Deassert rst_n during EXEC: all strobes drop to 0 asynchronously, state=IDLE, instr_ready=1. After release, a new ADD executes normally.

Source files
------------

// File: rtl/dp_controller_pkg.sv
// Shared types and encodings for the ARM32 data-processing controller:
// FSM states, ALU operation codes, opcode and condition-code values.
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        LOAD   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_EOR = 4'b0001;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ARM immediate: 8-bit value rotated right by twice the 4-bit rotate field.
    function automatic logic [31:0] rotate_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] doubled;
        logic [63:0] shifted;
        doubled = {24'b0, imm8, 24'b0, imm8};
        shifted = doubled >> {rot, 1'b0};
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/dp_controller_if.sv
// Instruction handshake between the issuing stage and the controller.
interface dp_controller_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic        undef;

    modport master (output instr, output instr_valid, input instr_ready, input done, input undef);
    modport slave  (input instr, input instr_valid, output instr_ready, output done, output undef);
endinterface

// File: rtl/dp_controller_cond_check.sv
// Evaluates an ARM condition code against N, Z, C, V; code 1111 never passes.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_controller.sv
// Multi-cycle controller for ARM32 data-processing instructions: latches one
// instruction, checks its condition and sequences load/execute/write-back strobes.
module dp_controller
    import arm_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    dp_controller_if.slave     bus,
    input  logic [31:0]        status_in,
    output logic [3:0]         w_addr,
    output logic [3:0]         A_addr,
    output logic [3:0]         B_addr,
    output logic [3:0]         shift_addr,
    output logic               wb_sel,
    output logic               w_en,
    output logic               en_A,
    output logic               en_B,
    output logic               en_C,
    output logic               en_status,
    output logic [1:0]         shift_op,
    output logic [31:0]        shift_imme,
    output logic               sel_shift,
    output logic               sel_A,
    output logic               sel_B,
    output logic [31:0]        imme_data,
    output logic [2:0]         ALU_op
);

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic [3:0]  opc;
    logic        opc_ok;
    logic        is_cmp;
    logic        instr_undef;
    logic        cond_pass;
    logic        unused_bits;

    assign opc         = ir[24:21];
    assign is_cmp      = (opc == OPC_CMP);
    assign instr_undef = !opc_ok || (ir[31:28] == COND_NV);
    assign unused_bits = ^{status_in[27:0], ir[27:26]};

    cond_check u_cond_check (
        .cond (ir[31:28]),
        .nzcv (status_in[31:28]),
        .pass (cond_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.instr_valid)
                ir <= bus.instr;
        end
    end

    // Skipped and undefined instructions go straight to DONE so no datapath strobe fires.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.instr_valid) state_next = DECODE;
            DECODE:  state_next = (instr_undef || !cond_pass) ? DONE : LOAD;
            LOAD:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        opc_ok = 1'b1;
        ALU_op = ALU_ADD;
        case (opc)
            OPC_AND: ALU_op = ALU_AND;
            OPC_EOR: ALU_op = ALU_EOR;
            OPC_SUB: ALU_op = ALU_SUB;
            OPC_ADD: ALU_op = ALU_ADD;
            OPC_ORR: ALU_op = ALU_ORR;
            OPC_MOV: ALU_op = ALU_ADD;
            OPC_CMP: ALU_op = ALU_SUB;
            default: opc_ok = 1'b0;
        endcase
    end

    assign A_addr     = ir[19:16];
    assign w_addr     = ir[15:12];
    assign B_addr     = ir[3:0];
    assign shift_addr = ir[11:8];
    assign shift_op   = ir[6:5];
    assign shift_imme = {27'b0, ir[11:7]};
    assign sel_shift  = !ir[25] && ir[4];
    assign sel_B      = ir[25];
    assign sel_A      = (opc == OPC_MOV);
    assign imme_data  = rotate_imm(ir[7:0], ir[11:8]);
    assign wb_sel     = 1'b0;

    assign bus.instr_ready = (state == IDLE);
    assign bus.done        = (state == DONE);
    assign bus.undef       = (state == DONE) && instr_undef;
    assign en_A            = (state == LOAD);
    assign en_B            = (state == LOAD);
    assign en_C            = (state == EXEC);
    assign en_status       = (state == EXEC) && (ir[20] || is_cmp);
    assign w_en            = (state == WB) && !is_cmp;

endmodule

// File: tb/tb_dp_controller.sv
// Directed bench for dp_controller: per-cycle strobe traces and decoded fields.
module tb_dp_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] status_in;
    logic [3:0]  w_addr, A_addr, B_addr, shift_addr;
    logic        wb_sel, w_en, en_A, en_B, en_C, en_status;
    logic [1:0]  shift_op;
    logic [31:0] shift_imme;
    logic        sel_shift, sel_A, sel_B;
    logic [31:0] imme_data;
    logic [2:0]  ALU_op;

    int checks = 0;
    int passes = 0;

    dp_controller_if bus ();

    dp_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .status_in  (status_in),
        .w_addr     (w_addr),
        .A_addr     (A_addr),
        .B_addr     (B_addr),
        .shift_addr (shift_addr),
        .wb_sel     (wb_sel),
        .w_en       (w_en),
        .en_A       (en_A),
        .en_B       (en_B),
        .en_C       (en_C),
        .en_status  (en_status),
        .shift_op   (shift_op),
        .shift_imme (shift_imme),
        .sel_shift  (sel_shift),
        .sel_A      (sel_A),
        .sel_B      (sel_B),
        .imme_data  (imme_data),
        .ALU_op     (ALU_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte layout: {instr_ready, en_A, en_B, en_C, en_status, w_en, done, undef}
    function automatic logic [7:0] snap();
        return {bus.instr_ready, en_A, en_B, en_C, en_status, w_en, bus.done, bus.undef};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issues one instruction, then keeps instr_valid high with a junk word while
    // busy so any illegal mid-instruction accept would corrupt the decoded fields.
    task automatic apply_stimulus(input string name, input logic [31:0] ins,
                                  input logic [31:0] status, input logic [47:0] exp_trace);
        status_in = status;
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr = 32'hE3A0F0AA;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            check_output($sformatf("%s c%0d", name, i), {24'b0, snap()},
                         {24'b0, exp_trace[8*(6-i) +: 8]});
            if (bus.instr_ready) bus.instr_valid = 1'b0;
        end
        bus.instr_valid = 1'b0;
    endtask

    localparam logic [47:0] TR_EXEC   = 48'h00_60_10_04_02_80;
    localparam logic [47:0] TR_EXEC_S = 48'h00_60_18_04_02_80;
    localparam logic [47:0] TR_CMP    = 48'h00_60_18_00_02_80;
    localparam logic [47:0] TR_SKIP   = 48'h00_02_80_80_80_80;
    localparam logic [47:0] TR_UNDEF  = 48'h00_03_80_80_80_80;

    initial begin
        rst_n           = 1'b0;
        status_in       = '0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        #1;
        check_output("reset strobes", {24'b0, snap()}, 32'h80);
        check_output("reset alu_op", {29'b0, ALU_op}, 32'd2);
        check_output("reset wb_sel", {31'b0, wb_sel}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("idle strobes", {24'b0, snap()}, 32'h80);

        apply_stimulus("add", 32'hE2821005, 32'h0, TR_EXEC);
        check_output("add A_addr", {28'b0, A_addr}, 32'd2);
        check_output("add w_addr", {28'b0, w_addr}, 32'd1);
        check_output("add sel_B", {31'b0, sel_B}, 32'd1);
        check_output("add imme", imme_data, 32'd5);
        check_output("add alu", {29'b0, ALU_op}, 32'd0);
        check_output("add sel_A", {31'b0, sel_A}, 32'd0);

        apply_stimulus("subs", 32'hE0533104, 32'h0, TR_EXEC_S);
        check_output("subs B_addr", {28'b0, B_addr}, 32'd4);
        check_output("subs shift_op", {30'b0, shift_op}, 32'd0);
        check_output("subs sel_shift", {31'b0, sel_shift}, 32'd0);
        check_output("subs shift_imme", shift_imme, 32'd2);
        check_output("subs alu", {29'b0, ALU_op}, 32'd1);
        check_output("subs w_addr", {28'b0, w_addr}, 32'd3);
        check_output("subs sel_B", {31'b0, sel_B}, 32'd0);

        apply_stimulus("add regshift", 32'hE0821314, 32'h0, TR_EXEC);
        check_output("regshift sel_shift", {31'b0, sel_shift}, 32'd1);
        check_output("regshift shift_addr", {28'b0, shift_addr}, 32'd3);
        check_output("regshift B_addr", {28'b0, B_addr}, 32'd4);

        apply_stimulus("moveq z1", 32'h03A004FF, 32'h4000_0000, TR_EXEC);
        check_output("moveq imme", imme_data, 32'hFF00_0000);
        check_output("moveq sel_A", {31'b0, sel_A}, 32'd1);
        check_output("moveq alu", {29'b0, ALU_op}, 32'd0);

        apply_stimulus("moveq z0", 32'h03A004FF, 32'h0, TR_SKIP);

        apply_stimulus("cmp", 32'hE1510002, 32'h0, TR_CMP);
        check_output("cmp alu", {29'b0, ALU_op}, 32'd1);
        check_output("cmp A_addr", {28'b0, A_addr}, 32'd1);

        apply_stimulus("rsb", 32'hE0610002, 32'h0, TR_UNDEF);
        apply_stimulus("cond nv", 32'hF2821005, 32'hF000_0000, TR_UNDEF);
        apply_stimulus("addge skip", 32'hA2821005, 32'h8000_0000, TR_SKIP);
        apply_stimulus("addlt exec", 32'hB2821005, 32'h8000_0000, TR_EXEC);
        apply_stimulus("addhi skip", 32'h82821005, 32'h6000_0000, TR_SKIP);

        // Abort an ADD in EXEC with an asynchronous reset, then run another one.
        @(negedge clk);
        bus.instr       = 32'hE2821005;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("abort pre en_C", {31'b0, en_C}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("abort strobes", {24'b0, snap()}, 32'h80);
        check_output("abort ir clear", {28'b0, A_addr}, 32'd0);
        @(posedge clk);
        #1;
        check_output("abort hold", {24'b0, snap()}, 32'h80);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("add after rst", 32'hE2821005, 32'h0, TR_EXEC);
        check_output("add after rst imme", imme_data, 32'd5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
